cic_iq_decim: RTL and testbench
===============================

# cic_iq_decim

Parametrised I/Q CIC decimator with post-CIC gain normalisation, replacing the fixed x10 CIC/shift/constant-multiplier chain in the receive path. It decimates a complex 16-bit baseband stream by a runtime rate R (2..MAX_RATE), applies a runtime right shift and a fractional gain multiplier, and emits rounded DOUT_W-bit I/Q samples with a valid strobe. It sits after the input sample registers and before the compensation FIR or output registers, in a single clock domain.

## Interface

- DIN_W, 16, input sample width (signed, per channel)
- DOUT_W, 16, output sample width (signed, per channel)
- STAGES, 4, CIC order N (1..6); differential delay fixed at 1
- MAX_RATE, 16, largest decimation rate; RATE_W = clog2(MAX_RATE+1)
- GAIN_W, 16, unsigned gain width, GAIN_W-2 fractional bits (16384 = 1.0 at default)
- ACC_W (derived), DIN_W + STAGES*clog2(MAX_RATE), integrator/comb width

- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- s_axis_data_tvalid  in  1  input sample strobe, one sample per asserted cycle
- s_axis_data_tdata_real  in  DIN_W  I input
- s_axis_data_tdata_imag  in  DIN_W  Q input
- cfg_load  in  1  single-cycle pulse: capture cfg_* and flush datapath
- cfg_rate  in  RATE_W  decimation rate R
- cfg_shift  in  clog2(ACC_W)  right shift before gain
- cfg_gain  in  GAIN_W  unsigned fractional gain
- m_axis_data_tvalid  out  1  one-cycle output strobe
- m_axis_data_tdata_real  out  DOUT_W  I output
- m_axis_data_tdata_imag  out  DOUT_W  Q output

## Operation

- Reset: all integrators, combs, phase counter, pipeline valids cleared; outputs 0, m_axis_data_tvalid 0; config regs rate=2, shift=0, gain=1.0.
- cfg_load: latches cfg_rate (clamped to 2..MAX_RATE), cfg_shift (clamped to ACC_W-1), cfg_gain; same-cycle soft flush identical to reset except config regs. Sample accepted in the same cycle is discarded. Output data regs hold last value; tvalid 0 during flush.
- Integrators: N cascaded per channel, each ACC_W two's-complement, wrap-around arithmetic (required for CIC correctness); advance only on s_axis_data_tvalid.
- Phase counter: 0..R-1, increments per accepted sample; on the sample where counter = R-1 it wraps to 0 and issues a decimation strobe capturing the last integrator.
- Comb section: N stages, one register stage each, ACC_W wrap arithmetic, advanced by the strobe pipeline.
- Scale: y = (c + 2^(shift-1)) >>> shift (round half up; shift 0 = no rounding); then p = y*gain, rounded the same way by GAIN_W-2 bits.
- Output conversion to DOUT_W per Configuration.
- I and Q share counter, strobes and config; channels are bit-identical paths.
- Decimated strobes may arrive every R cycles minimum; pipeline is fully pipelined, no stall, no backpressure.

## Timing

- Latency L = STAGES+4 cycles from the accepting edge of the frame-completing input to m_axis_data_tvalid high: 1 capture, STAGES comb, 1 shift/round, 1 multiply, 1 output reg.
- m_axis_data_tvalid high exactly one cycle per R accepted inputs; data regs update only then and hold otherwise.
- cfg_load or rst asserted while strobes are in flight: all in-flight strobes cancelled; no output strobe for any sample accepted before it.
- First output after reset/flush: after R accepted samples plus L cycles (transient of N-1 frames is valid CIC output, not suppressed).

## Configuration

- CIC_IQ_DECIM_SAT_EN defined: final conversion saturates to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
- Undefined: final conversion keeps the low DOUT_W bits (wrap), no compare logic synthesised.

## Test plan

- DC: rate 10, shift 13, gain 16384, I=1000, Q=-1000 every cycle -> after settling, each strobe I=1221, Q=-1221 (1e7/8192 = 1220.70 rounded; -1220.70+0.5 floored).
- Impulse: rate 4, shift 0, gain 16384, one I=1 then zeros -> sum of all I outputs = 64, Q outputs all 0, strobes every 4 accepted inputs.
- Saturation: rate 16, shift 0, gain 16384, I=32767 DC -> with CIC_IQ_DECIM_SAT_EN output 32767; without it output 0 (low 16 bits of 32767*65536).
- Gated input: tvalid 1 every 3rd cycle, rate 5 -> strobe every 15 cycles, L=8 cycles after the 5th accepted sample, values equal to the continuous-input run.
- cfg_load mid-frame with tvalid same cycle: rate 4 -> 8 -> that sample dropped, pending strobes cancelled, next strobe after 8 further accepted samples + L, data regs unchanged until then.
- rst mid-run -> next cycle all outputs 0, tvalid 0, config back to rate 2/shift 0/gain 1.0.

Source files
------------

// File: rtl/cic_iq_decim.sv
// cic_iq_decim: I/Q CIC decimator (rate 2..MAX_RATE) with rounded shift, gain and output.
// Ports: clk/rst (sync, active-high), s_axis_data_* input stream, cfg_* load/rate/shift/gain,
// m_axis_data_* output stream. Define CIC_IQ_DECIM_SAT_EN to saturate the output (else wrap).
module cic_iq_decim #(
  parameter int DIN_W    = 16,
  parameter int DOUT_W   = 16,
  parameter int STAGES   = 4,
  parameter int MAX_RATE = 16,
  parameter int GAIN_W   = 16,
  localparam int RATE_W  = $clog2(MAX_RATE + 1),
  localparam int ACC_W   = DIN_W + STAGES * $clog2(MAX_RATE),
  localparam int SHIFT_W = $clog2(ACC_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_axis_data_tvalid,
  input  logic signed [DIN_W-1:0]  s_axis_data_tdata_real,
  input  logic signed [DIN_W-1:0]  s_axis_data_tdata_imag,
  input  logic                     cfg_load,
  input  logic [RATE_W-1:0]        cfg_rate,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic [GAIN_W-1:0]        cfg_gain,
  output logic                     m_axis_data_tvalid,
  output logic signed [DOUT_W-1:0] m_axis_data_tdata_real,
  output logic signed [DOUT_W-1:0] m_axis_data_tdata_imag
);
  localparam int SH_W  = ACC_W + 1;
  localparam int MUL_W = SH_W + GAIN_W + 1;
  localparam logic signed [MUL_W-1:0] P_RND = MUL_W'(2 ** (GAIN_W - 3));
`ifdef CIC_IQ_DECIM_SAT_EN
  localparam logic signed [MUL_W-1:0] O_MAX = MUL_W'(2 ** (DOUT_W - 1) - 1);
  localparam logic signed [MUL_W-1:0] O_MIN = ~O_MAX;
`endif

  logic [RATE_W-1:0]  rate_r;
  logic [SHIFT_W-1:0] shift_r;
  logic [GAIN_W-1:0]  gain_r;
  logic [SHIFT_W:0]   shift_ext;

  logic               flush;
  logic [RATE_W-1:0]  cnt;
  logic               stb;
  logic               v_cap;
  logic [STAGES-1:0]  v_cmb;
  logic               v_sh;
  logic               v_mul;

  logic signed [DIN_W-1:0]  din       [2];
  logic signed [ACC_W-1:0]  integ     [2][STAGES];
  logic signed [ACC_W-1:0]  integ_nxt [2][STAGES];
  logic signed [ACC_W-1:0]  cap       [2];
  logic signed [ACC_W-1:0]  dly       [2][STAGES];
  logic signed [ACC_W-1:0]  cmb       [2][STAGES];
  logic signed [SH_W-1:0]   sh_nxt    [2];
  logic signed [SH_W-1:0]   sh        [2];
  logic signed [SH_W-1:0]   sh_rnd;
  logic signed [MUL_W-1:0]  mul       [2];
  logic signed [DOUT_W-1:0] dout_nxt  [2];
`ifdef CIC_IQ_DECIM_SAT_EN
  logic signed [MUL_W-1:0]  pr        [2];
`endif

  assign flush     = rst | cfg_load;
  assign shift_ext = {1'b0, cfg_shift};
  assign din[0]    = s_axis_data_tdata_real;
  assign din[1]    = s_axis_data_tdata_imag;

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_r  <= RATE_W'(2);
      shift_r <= '0;
      gain_r  <= GAIN_W'(2 ** (GAIN_W - 2));
    end else if (cfg_load) begin
      if (cfg_rate < RATE_W'(2))
        rate_r <= RATE_W'(2);
      else if (cfg_rate > RATE_W'(MAX_RATE))
        rate_r <= RATE_W'(MAX_RATE);
      else
        rate_r <= cfg_rate;
      if (shift_ext > (SHIFT_W + 1)'(ACC_W - 1))
        shift_r <= SHIFT_W'(ACC_W - 1);
      else
        shift_r <= cfg_shift;
      gain_r <= cfg_gain;
    end
  end

  // Integrators chain combinationally so a frame's last sample
  // reaches the final integrator on its own accepting edge.
  always_comb begin
    sh_rnd = '0;
    if (shift_r != '0)
      sh_rnd = SH_W'(1) << (shift_r - 1'b1);
    for (int c = 0; c < 2; c++) begin
      integ_nxt[c][0] = integ[c][0] + ACC_W'(din[c]);
      for (int k = 1; k < STAGES; k++)
        integ_nxt[c][k] = integ[c][k] + integ_nxt[c][k-1];
      sh_nxt[c] = (SH_W'(cmb[c][STAGES-1]) + sh_rnd) >>> shift_r;
`ifdef CIC_IQ_DECIM_SAT_EN
      pr[c] = (mul[c] + P_RND) >>> (GAIN_W - 2);
      if (pr[c] > O_MAX)
        dout_nxt[c] = DOUT_W'(O_MAX);
      else if (pr[c] < O_MIN)
        dout_nxt[c] = DOUT_W'(O_MIN);
      else
        dout_nxt[c] = DOUT_W'(pr[c]);
`else
      dout_nxt[c] = DOUT_W'((mul[c] + P_RND) >>> (GAIN_W - 2));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      cnt   <= '0;
      stb   <= 1'b0;
      v_cap <= 1'b0;
      v_cmb <= '0;
      v_sh  <= 1'b0;
      v_mul <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        cap[c] <= '0;
        sh[c]  <= '0;
        mul[c] <= '0;
        for (int k = 0; k < STAGES; k++) begin
          integ[c][k] <= '0;
          dly[c][k]   <= '0;
          cmb[c][k]   <= '0;
        end
      end
    end else begin
      stb <= 1'b0;
      if (s_axis_data_tvalid) begin
        for (int c = 0; c < 2; c++)
          for (int k = 0; k < STAGES; k++)
            integ[c][k] <= integ_nxt[c][k];
        if (cnt == rate_r - 1'b1) begin
          cnt <= '0;
          stb <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      v_cap    <= stb;
      v_cmb[0] <= v_cap;
      for (int k = 1; k < STAGES; k++)
        v_cmb[k] <= v_cmb[k-1];
      v_sh  <= v_cmb[STAGES-1];
      v_mul <= v_sh;
      for (int c = 0; c < 2; c++) begin
        if (stb)
          cap[c] <= integ[c][STAGES-1];
        if (v_cap) begin
          cmb[c][0] <= cap[c] - dly[c][0];
          dly[c][0] <= cap[c];
        end
        for (int k = 1; k < STAGES; k++) begin
          if (v_cmb[k-1]) begin
            cmb[c][k] <= cmb[c][k-1] - dly[c][k];
            dly[c][k] <= cmb[c][k-1];
          end
        end
        if (v_cmb[STAGES-1])
          sh[c] <= sh_nxt[c];
        if (v_sh)
          mul[c] <= MUL_W'(sh[c]) * MUL_W'($signed({1'b0, gain_r}));
      end
    end
  end

  // Data registers keep their value across a soft flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_data_tvalid     <= 1'b0;
      m_axis_data_tdata_real <= '0;
      m_axis_data_tdata_imag <= '0;
    end else if (cfg_load) begin
      m_axis_data_tvalid <= 1'b0;
    end else begin
      m_axis_data_tvalid <= v_mul;
      if (v_mul) begin
        m_axis_data_tdata_real <= dout_nxt[0];
        m_axis_data_tdata_imag <= dout_nxt[1];
      end
    end
  end
endmodule

// File: tb/tb_cic_iq_decim.sv
// tb_cic_iq_decim: randomized scoreboard bench for cic_iq_decim.
// Expected outputs come from a direct FIR model of the CIC response.
module tb_cic_iq_decim;
  localparam int DIN_W    = 16;
  localparam int DOUT_W   = 16;
  localparam int N        = 4;
  localparam int MAX_RATE = 16;
  localparam int GAIN_W   = 16;
  localparam int RATE_W   = $clog2(MAX_RATE + 1);
  localparam int ACC_W    = DIN_W + N * $clog2(MAX_RATE);
  localparam int SHIFT_W  = $clog2(ACC_W);
  localparam int L        = N + 4;
  localparam longint OMAX = 2 ** (DOUT_W - 1) - 1;
  localparam longint OMIN = -(2 ** (DOUT_W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tvalid = 1'b0;
  logic signed [DIN_W-1:0] d_re = '0;
  logic signed [DIN_W-1:0] d_im = '0;
  logic cfg_load = 1'b0;
  logic [RATE_W-1:0] cfg_rate = '0;
  logic [SHIFT_W-1:0] cfg_shift = '0;
  logic [GAIN_W-1:0] cfg_gain = '0;
  logic m_valid;
  logic signed [DOUT_W-1:0] m_re;
  logic signed [DOUT_W-1:0] m_im;

  cic_iq_decim #(
    .DIN_W(DIN_W), .DOUT_W(DOUT_W), .STAGES(N),
    .MAX_RATE(MAX_RATE), .GAIN_W(GAIN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_data_tvalid(tvalid),
    .s_axis_data_tdata_real(d_re),
    .s_axis_data_tdata_imag(d_im),
    .cfg_load(cfg_load),
    .cfg_rate(cfg_rate),
    .cfg_shift(cfg_shift),
    .cfg_gain(cfg_gain),
    .m_axis_data_tvalid(m_valid),
    .m_axis_data_tdata_real(m_re),
    .m_axis_data_tdata_imag(m_im)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int at;
  } exp_t;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  int hist_i[$];
  int hist_q[$];
  longint h[$];
  int m_rate = 2;
  int m_shift = 0;
  longint m_gain = 16384;
  int last_i = 0;
  int last_q = 0;
  longint sum_i = 0;
  longint sum_q = 0;
  int n_out = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Impulse response of N cascaded length-R moving sums.
  function automatic void set_cfg(int r, int s, longint g);
    m_rate  = (r < 2) ? 2 : (r > MAX_RATE) ? MAX_RATE : r;
    m_shift = (s > ACC_W - 1) ? ACC_W - 1 : s;
    m_gain  = g;
    h = {};
    h.push_back(1);
    repeat (N) begin
      longint t[$];
      t = {};
      for (int k = 0; k < h.size() + m_rate - 1; k++) begin
        longint a;
        a = 0;
        for (int j = 0; j < m_rate; j++)
          if (k - j >= 0 && k - j < h.size())
            a += h[k-j];
        t.push_back(a);
      end
      h = t;
    end
  endfunction

  function automatic longint fir(bit q);
    longint a;
    int n;
    a = 0;
    n = hist_i.size() - 1;
    for (int j = 0; j < h.size(); j++)
      if (n - j >= 0)
        a += h[j] * longint'(q ? hist_q[n-j] : hist_i[n-j]);
    return a;
  endfunction

  function automatic int scale(longint c);
    longint y;
    longint p;
`ifndef CIC_IQ_DECIM_SAT_EN
    logic [63:0] pv;
`endif
    y = c;
    if (m_shift > 0)
      y = (c + (longint'(1) <<< (m_shift - 1))) >>> m_shift;
    p = y * m_gain;
    p = (p + (longint'(1) <<< (GAIN_W - 3))) >>> (GAIN_W - 2);
`ifdef CIC_IQ_DECIM_SAT_EN
    if (p > OMAX) p = OMAX;
    else if (p < OMIN) p = OMIN;
    return int'(p);
`else
    pv = p;
    return int'($signed(pv[DOUT_W-1:0]));
`endif
  endfunction

  function automatic int rnd16();
    logic [15:0] t;
    t = 16'($urandom);
    return int'($signed(t));
  endfunction

  task automatic send(bit v, int re, int im);
    exp_t e;
    @(negedge clk);
    tvalid = v;
    d_re = DIN_W'(re);
    d_im = DIN_W'(im);
    if (v) begin
      hist_i.push_back(re);
      hist_q.push_back(im);
      if (hist_i.size() % m_rate == 0) begin
        e.re = scale(fir(1'b0));
        e.im = scale(fir(1'b1));
        e.at = cyc + 1 + L;
        sb.push_back(e);
      end
    end
  endtask

  task automatic do_cfg(int r, int s, int g, bit v, int re, int im);
    @(negedge clk);
    cfg_load  = 1'b1;
    cfg_rate  = RATE_W'(r);
    cfg_shift = SHIFT_W'(s);
    cfg_gain  = GAIN_W'(g);
    tvalid    = v;
    d_re      = DIN_W'(re);
    d_im      = DIN_W'(im);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    tvalid   = 1'b0;
    sb.delete();
    hist_i.delete();
    hist_q.delete();
    set_cfg(r, s, g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    hist_i.delete();
    hist_q.delete();
    set_cfg(2, 0, 16384);
    last_i = 0;
    last_q = 0;
    check("rst_tvalid", m_valid, 0);
    check("rst_re", m_re, 0);
    check("rst_im", m_im, 0);
  endtask

  task automatic drain();
    repeat (L + 2) send(1'b0, 0, 0);
    check("sb_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].at < cyc) begin
        check("missed_strobe_at", cyc, sb[0].at);
        void'(sb.pop_front());
      end
      if (m_valid) begin
        if (sb.size() == 0) begin
          check("spurious_tvalid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("strobe_cycle", cyc, mon_e.at);
          check("out_re", m_re, mon_e.re);
          check("out_im", m_im, mon_e.im);
          last_i = mon_e.re;
          last_q = mon_e.im;
          sum_i += m_re;
          sum_q += m_im;
          n_out++;
        end
      end else begin
        check("hold_re", m_re, last_i);
        check("hold_im", m_im, last_q);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    int r;
    set_cfg(2, 0, 16384);
    repeat (2) @(negedge clk);
    do_reset();
    mon_en = 1'b1;

    for (int i = 0; i < 20; i++) send(1'b1, rnd16(), rnd16());
    drain();

    do_cfg(10, 13, 16384, 1'b0, 0, 0);
    repeat (100) send(1'b1, 1000, -1000);
    drain();
    check("dc_re", m_re, 1221);
    check("dc_im", m_im, -1221);

    do_cfg(4, 0, 16384, 1'b0, 0, 0);
    sum_i = 0;
    sum_q = 0;
    n_out = 0;
    send(1'b1, 1, 0);
    repeat (31) send(1'b1, 0, 0);
    drain();
    check("impulse_sum_re", sum_i, 64);
    check("impulse_sum_im", sum_q, 0);
    check("impulse_strobes", n_out, 8);

    do_cfg(16, 0, 16384, 1'b0, 0, 0);
    repeat (80) send(1'b1, 32767, -32768);
    drain();
`ifdef CIC_IQ_DECIM_SAT_EN
    check("sat_re", m_re, 32767);
    check("sat_im", m_im, -32768);
`else
    check("wrap_re", m_re, 0);
    check("wrap_im", m_im, 0);
`endif

    do_cfg(5, 4, 16384, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      send(1'b1, rnd16(), rnd16());
      send(1'b0, rnd16(), rnd16());
      send(1'b0, rnd16(), rnd16());
    end
    drain();

    do_cfg(4, 2, 20000, 1'b0, 0, 0);
    repeat (6) send(1'b1, rnd16(), rnd16());
    do_cfg(8, 2, 20000, 1'b1, 12345, -54);
    repeat (24) send(1'b1, rnd16(), rnd16());
    drain();

    do_cfg(0, 31, 16384, 1'b0, 0, 0);
    repeat (12) send(1'b1, rnd16(), rnd16());
    drain();
    do_cfg(31, 3, 40000, 1'b0, 0, 0);
    repeat (40) send(1'b1, rnd16(), rnd16());
    drain();

    for (int t = 0; t < 8; t++) begin
      r = int'($urandom_range(2, 16));
      do_cfg(r, int'($urandom_range(0, 18)), int'($urandom_range(0, 65535)),
             1'b1, rnd16(), rnd16());
      for (int i = 0; i < 4 * r + int'($urandom_range(0, 7)); i++)
        send(($urandom_range(0, 3) != 0), rnd16(), rnd16());
      if (t % 2 == 1) drain();
    end
    drain();

    do_cfg(6, 3, 30000, 1'b0, 0, 0);
    repeat (9) send(1'b1, rnd16(), rnd16());
    do_reset();
    repeat (10) send(1'b1, rnd16(), rnd16());
    drain();

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
